// File: rtl/rgb_pkg.sv
// Shared constants, colour table and FSM encoding for the RGB fade controller.
package rgb_pkg;

  localparam logic [7:0] DUTY_MAX = 8'd100;

  localparam logic [2:0] COL_OFF     = 3'd0;
  localparam logic [2:0] COL_RED     = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_BLUE    = 3'd3;
  localparam logic [2:0] COL_YELLOW  = 3'd4;
  localparam logic [2:0] COL_ORANGE  = 3'd5;
  localparam logic [2:0] COL_MAGENTA = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RAMP = 2'd2;

  typedef struct packed {
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
  } level_t;

  function automatic level_t color_level(input logic [2:0] color);
    level_t lvl;
    case (color)
      COL_RED:     lvl = '{r: 7'd100, g: 7'd0,   b: 7'd0};
      COL_GREEN:   lvl = '{r: 7'd0,   g: 7'd100, b: 7'd0};
      COL_BLUE:    lvl = '{r: 7'd0,   g: 7'd0,   b: 7'd100};
      COL_YELLOW:  lvl = '{r: 7'd100, g: 7'd100, b: 7'd0};
      COL_ORANGE:  lvl = '{r: 7'd100, g: 7'd40,  b: 7'd0};
      COL_MAGENTA: lvl = '{r: 7'd100, g: 7'd0,   b: 7'd100};
      COL_WHITE:   lvl = '{r: 7'd100, g: 7'd100, b: 7'd100};
      default:     lvl = '{r: 7'd0,   g: 7'd0,   b: 7'd0};
    endcase
    return lvl;
  endfunction

  // level and intensity are both <= 100, so the product fits in 14 bits.
  function automatic logic [7:0] scale_level(input logic [6:0] level,
                                             input logic [6:0] intensity);
    logic [13:0] prod;
    prod = 14'(level) * 14'(intensity);
    return 8'(prod / 14'd100);
  endfunction

endpackage

// File: rtl/rgb_ramp_channel.sv
// One colour channel: holds a target and walks its duty one unit per step toward it.
module rgb_ramp_channel
  import rgb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] target_in,
  input  logic       step,
  output logic [7:0] duty,
  output logic       at_target
);

  logic [7:0] target;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty   <= 8'd0;
      target <= 8'd0;
    end else begin
      if (load) target <= (target_in > DUTY_MAX) ? DUTY_MAX : target_in;
      if (step && (duty != target)) begin
        duty <= (duty < target) ? duty + 8'd1 : duty - 8'd1;
      end
    end
  end

  assign at_target = (duty == target);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Colour/intensity sequencer feeding three PWM duty inputs with smooth ramps.
// Optional blink gating of the outputs is built when BLINK_EN is defined.
module rgb_fade_ctrl
  import rgb_pkg::*;
#(
  parameter int STEP_DIV = 1000
`ifdef BLINK_EN
  , parameter int BLINK_HALF = 50000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_color,
  input  logic [7:0] cmd_intensity,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done,
  output state_t     fsm_state
`ifdef BLINK_EN
  , input  logic     blink
`endif
);

  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        color_q;
  logic [6:0]        intensity_q;
  logic              accept;
  logic              all_at;
  logic              load;
  logic              step;
  level_t            lvl;
  logic [7:0]        int_r, int_g, int_b;
  logic              at_r, at_g, at_b;

  // Handshake: a command transfers on any cycle with cmd_valid & cmd_ready;
  // cmd_ready is low during rst and in LOAD, high in IDLE and RAMP.
  assign cmd_ready = !rst && (state != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign all_at    = at_r && at_g && at_b;
  assign load      = (state == ST_LOAD);
  assign step      = (state == ST_RAMP) && (tick == TICK_LAST);
  assign busy      = !rst && ((state == ST_LOAD) || (state == ST_RAMP));
  // A command landing on the completing cycle suppresses done.
  assign done      = !rst && (state == ST_RAMP) && all_at && !accept;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tick        <= '0;
      color_q     <= COL_OFF;
      intensity_q <= 7'd0;
    end else begin
      if (accept) begin
        color_q     <= cmd_color;
        intensity_q <= (cmd_intensity > DUTY_MAX) ? 7'(DUTY_MAX) : cmd_intensity[6:0];
      end
      case (state)
        ST_IDLE: begin
          tick <= '0;
          if (accept) state <= ST_LOAD;
        end
        ST_LOAD: begin
          tick  <= '0;
          state <= ST_RAMP;
        end
        ST_RAMP: begin
          tick <= (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
          if (accept)      state <= ST_LOAD;
          else if (all_at) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lvl = color_level(color_q);

  rgb_ramp_channel u_ch_r (
    .clk(clk), .rst(rst), .load(load), .target_in(scale_level(lvl.r, intensity_q)),
    .step(step), .duty(int_r), .at_target(at_r)
  );
  rgb_ramp_channel u_ch_g (
    .clk(clk), .rst(rst), .load(load), .target_in(scale_level(lvl.g, intensity_q)),
    .step(step), .duty(int_g), .at_target(at_g)
  );
  rgb_ramp_channel u_ch_b (
    .clk(clk), .rst(rst), .load(load), .target_in(scale_level(lvl.b, intensity_q)),
    .step(step), .duty(int_b), .at_target(at_b)
  );

`ifdef BLINK_EN
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;

  always_ff @(posedge clk) begin
    if (rst || !blink) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= !blink_off;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Only the outputs are gated; the internal ramp keeps running.
  assign duty_r = blink_off ? 8'd0 : int_r;
  assign duty_g = blink_off ? 8'd0 : int_g;
  assign duty_b = blink_off ? 8'd0 : int_b;
`else
  assign duty_r = int_r;
  assign duty_g = int_g;
  assign duty_b = int_b;
`endif

endmodule
